// File: rtl/episode_if.sv
// Transition-datapath and Q-update handshake bundle for the episode controller.
// The master side is the controller; the slave side is the datapath and the update unit.
interface episode_if #(
    parameter int unsigned SW = 5,
    parameter int unsigned AW = 2
);
    logic [SW-1:0] ns_st;
    logic [AW-1:0] ns_at;
    logic          ns_valid_in;
    logic [SW-1:0] ns_next_state;

    logic          tr_valid;
    logic          tr_ready;
    logic [SW-1:0] tr_st;
    logic [SW-1:0] tr_next;
    logic [AW-1:0] tr_at;
    logic          tr_blocked;
    logic          tr_last;

    modport master (
        output ns_st, ns_at, ns_valid_in,
        input  ns_next_state,
        output tr_valid, tr_st, tr_next, tr_at, tr_blocked, tr_last,
        input  tr_ready
    );

    modport slave (
        input  ns_st, ns_at, ns_valid_in,
        output ns_next_state,
        input  tr_valid, tr_st, tr_next, tr_at, tr_blocked, tr_last,
        output tr_ready
    );
endinterface

// File: rtl/episode_controller.sv
// Sequences one Q-learning episode: epsilon-greedy action choice, drives the
// next-state datapath, captures the transition and hands it to the Q-update unit.
module episode_controller #(
    parameter int unsigned              STATES_WIDTH  = 5,
    parameter int unsigned              ACTIONS_WIDTH = 2,
    parameter logic [STATES_WIDTH-1:0]  GOAL_STATE    = 24,
    parameter int unsigned              MAX_STEPS     = 64,
    // 9 bits so that 256 forces exploration on every step
    parameter logic [8:0]               EPSILON       = 9'd26,
    parameter logic [7:0]               LFSR_SEED     = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [STATES_WIDTH-1:0]   start_state_i,
    input  logic [ACTIONS_WIDTH-1:0]  greedy_action_i,
    episode_if.master                 bus,
    output logic                      busy_o,
    output logic                      episode_done_o,
    output logic                      done_goal_o,
    output logic [7:0]                step_count_o,
    output logic [15:0]               episode_count_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [7:0] MAX_STEPS_B = 8'(MAX_STEPS);

    state_e                     state_q, state_d;
    logic [STATES_WIDTH-1:0]    cur_state_q, cur_state_d;
    logic [ACTIONS_WIDTH-1:0]   ns_at_q, ns_at_d;
    logic [7:0]                 lfsr_q, lfsr_d;
    logic [STATES_WIDTH-1:0]    tr_st_q, tr_st_d;
    logic [STATES_WIDTH-1:0]    tr_next_q, tr_next_d;
    logic [ACTIONS_WIDTH-1:0]   tr_at_q, tr_at_d;
    logic                       tr_blocked_q, tr_blocked_d;
    logic                       tr_last_q, tr_last_d;
    logic [7:0]                 step_q, step_d;
    logic [15:0]                ep_cnt_q, ep_cnt_d;
    logic                       done_goal_q, done_goal_d;

    logic                       explore;
    logic [7:0]                 lfsr_nxt;
    logic [7:0]                 step_inc;

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign explore  = ({1'b0, lfsr_q} < EPSILON);
    assign step_inc = step_q + 8'd1;

    // state and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_state_q  <= '0;
            ns_at_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            tr_st_q      <= '0;
            tr_next_q    <= '0;
            tr_at_q      <= '0;
            tr_blocked_q <= 1'b0;
            tr_last_q    <= 1'b0;
            step_q       <= '0;
            ep_cnt_q     <= '0;
            done_goal_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_state_q  <= cur_state_d;
            ns_at_q      <= ns_at_d;
            lfsr_q       <= lfsr_d;
            tr_st_q      <= tr_st_d;
            tr_next_q    <= tr_next_d;
            tr_at_q      <= tr_at_d;
            tr_blocked_q <= tr_blocked_d;
            tr_last_q    <= tr_last_d;
            step_q       <= step_d;
            ep_cnt_q     <= ep_cnt_d;
            done_goal_q  <= done_goal_d;
        end
    end

    // next-state logic: episode sequencing and transition capture
    always_comb begin
        state_d      = state_q;
        cur_state_d  = cur_state_q;
        ns_at_d      = ns_at_q;
        lfsr_d       = lfsr_q;
        tr_st_d      = tr_st_q;
        tr_next_d    = tr_next_q;
        tr_at_d      = tr_at_q;
        tr_blocked_d = tr_blocked_q;
        tr_last_d    = tr_last_q;
        step_d       = step_q;
        ep_cnt_d     = ep_cnt_q;
        done_goal_d  = done_goal_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cur_state_d = start_state_i;
                    step_d      = '0;
                    done_goal_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ns_at_d = explore ? ACTIONS_WIDTH'(lfsr_q[1:0]) : greedy_action_i;
                lfsr_d  = lfsr_nxt;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // datapath result is recorded unmodified, even when it looks wrong
                tr_st_d      = cur_state_q;
                tr_at_d      = ns_at_q;
                tr_next_d    = bus.ns_next_state;
                tr_blocked_d = (bus.ns_next_state == cur_state_q);
                step_d       = step_inc;
                tr_last_d    = (bus.ns_next_state == GOAL_STATE) || (step_inc == MAX_STEPS_B);
                state_d      = S_UPDATE;
            end
            S_UPDATE: begin
                if (bus.tr_ready) begin
                    cur_state_d = tr_next_q;
                    if (tr_last_q) begin
                        // goal wins when it coincides with the step limit
                        done_goal_d = (tr_next_q == GOAL_STATE);
                        ep_cnt_d    = ep_cnt_q + 16'd1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ns_st       = cur_state_q;
    assign bus.ns_at       = ns_at_q;
    assign bus.ns_valid_in = (state_q == S_ISSUE);

    assign bus.tr_valid    = (state_q == S_UPDATE);
    assign bus.tr_st       = tr_st_q;
    assign bus.tr_next     = tr_next_q;
    assign bus.tr_at       = tr_at_q;
    assign bus.tr_blocked  = tr_blocked_q;
    assign bus.tr_last     = tr_last_q;

    assign busy_o          = (state_q != S_IDLE);
    assign episode_done_o  = (state_q == S_DONE);
    assign done_goal_o     = done_goal_q;
    assign step_count_o    = step_q;
    assign episode_count_o = ep_cnt_q;

endmodule

// File: tb/tb_episode_controller.sv
// Bench for episode_controller: plays the grid datapath and the Q-update unit,
// predicting every record from grid rules and an explicit epsilon-greedy model.
module tb_episode_controller;

    localparam logic [4:0] GOAL = 5'd24;
    localparam int         MAXS = 6;
    localparam logic [8:0] EPS  = 9'd64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  start_state_i = '0;
    logic [1:0]  greedy_action_i = '0;
    logic        busy_o, episode_done_o, done_goal_o;
    logic [7:0]  step_count_o;
    logic [15:0] episode_count_o;

    episode_if #(.SW(5), .AW(2)) bus();

    episode_controller #(
        .STATES_WIDTH (5),
        .ACTIONS_WIDTH(2),
        .GOAL_STATE   (GOAL),
        .MAX_STEPS    (MAXS),
        .EPSILON      (EPS),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .start_state_i  (start_state_i),
        .greedy_action_i(greedy_action_i),
        .bus            (bus),
        .busy_o         (busy_o),
        .episode_done_o (episode_done_o),
        .done_goal_o    (done_goal_o),
        .step_count_o   (step_count_o),
        .episode_count_o(episode_count_o)
    );

    always #5 clk = ~clk;

    // 5x5 grid move; Left from column 0 deliberately lands on state 0
    function automatic logic [4:0] grid_move(input logic [4:0] s, input logic [1:0] a);
        int r, c, n;
        r = int'(s) / 5;
        c = int'(s) % 5;
        n = int'(s);
        case (a)
            2'd0: n = (r == 0) ? int'(s) : int'(s) - 5;
            2'd1: n = (r == 4) ? int'(s) : int'(s) + 5;
            2'd2: n = (c == 4) ? int'(s) : int'(s) + 1;
            default: n = (c == 0) ? 0 : int'(s) - 1;
        endcase
        return 5'(n);
    endfunction

    always_comb bus.ns_next_state = grid_move(bus.ns_st, bus.ns_at);

    // polynomial x^8+x^6+x^5+x^4+1: new bit is parity of bits 7,5,4,3
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & 8'b1011_1000)};
    endfunction

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  lfsr_m;
    logic [15:0] ep_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_busy",     32'(busy_o), 0);
        chk("rst_done",     32'(episode_done_o), 0);
        chk("rst_goal",     32'(done_goal_o), 0);
        chk("rst_steps",    32'(step_count_o), 0);
        chk("rst_epcnt",    32'(episode_count_o), 0);
        chk("rst_nsvalid",  32'(bus.ns_valid_in), 0);
        chk("rst_nsst",     32'(bus.ns_st), 0);
        chk("rst_nsat",     32'(bus.ns_at), 0);
        chk("rst_trvalid",  32'(bus.tr_valid), 0);
        chk("rst_trst",     32'(bus.tr_st), 0);
        chk("rst_trnext",   32'(bus.tr_next), 0);
        chk("rst_trat",     32'(bus.tr_at), 0);
        chk("rst_trblk",    32'(bus.tr_blocked), 0);
        chk("rst_trlast",   32'(bus.tr_last), 0);
    endtask

    // gmode < 0: random greedy action each step; abort_step > 0: reset in WAIT of that step
    task automatic run_episode(input logic [4:0] s0, input int gmode,
                               input int stall_lo, input int stall_hi, input int abort_step);
        int         steps, stall, cyc, stall_sum;
        logic [4:0] cur, nxt;
        logic [1:0] g, a;
        logic       last;
        start_state_i = s0;
        start_i       = 1'b1;
        tick();
        cyc = 1; stall_sum = 0;
        cur = s0; steps = 0; last = 1'b0;
        chk("start_busy",  32'(busy_o), 1);
        chk("start_goal0", 32'(done_goal_o), 0);
        chk("start_step0", 32'(step_count_o), 0);
        while (!last) begin
            chk("issue_valid", 32'(bus.ns_valid_in), 1);
            chk("issue_st",    32'(bus.ns_st), 32'(cur));
            chk("issue_trv",   32'(bus.tr_valid), 0);
            g = (gmode < 0) ? 2'($urandom) : 2'(gmode);
            greedy_action_i = g;
            // noise on start while busy must be ignored
            start_i       = 1'($urandom);
            start_state_i = 5'($urandom_range(24, 0));
            a = ({1'b0, lfsr_m} < EPS) ? lfsr_m[1:0] : g;
            lfsr_m = lfsr_next(lfsr_m);
            tick(); cyc++;
            chk("wait_at",     32'(bus.ns_at), 32'(a));
            chk("wait_st",     32'(bus.ns_st), 32'(cur));
            chk("wait_nsv",    32'(bus.ns_valid_in), 0);
            chk("wait_trv",    32'(bus.tr_valid), 0);
            nxt = grid_move(cur, a);
            steps++;
            last = (nxt == GOAL) || (steps == MAXS);
            if (steps == abort_step) begin
                rst_n = 1'b0;
                tick();
                rst_n   = 1'b1;
                start_i = 1'b0;
                chk_reset_state();
                lfsr_m = 8'hA5;
                ep_m   = '0;
                tick();
                chk("abort_idle", 32'(busy_o), 0);
                chk("abort_nodn", 32'(episode_done_o), 0);
                return;
            end
            tick(); cyc++;
            stall = $urandom_range(stall_hi, stall_lo);
            stall_sum += stall;
            bus.tr_ready = 1'b0;
            for (int k = 0; k <= stall; k++) begin
                if (k == stall) bus.tr_ready = 1'b1;
                chk("upd_valid", 32'(bus.tr_valid), 1);
                chk("upd_st",    32'(bus.tr_st), 32'(cur));
                chk("upd_next",  32'(bus.tr_next), 32'(nxt));
                chk("upd_at",    32'(bus.tr_at), 32'(a));
                chk("upd_blk",   32'(bus.tr_blocked), 32'(nxt == cur));
                chk("upd_last",  32'(bus.tr_last), 32'(last));
                chk("upd_steps", 32'(step_count_o), 32'(steps));
                chk("upd_nsv",   32'(bus.ns_valid_in), 0);
                chk("upd_done",  32'(episode_done_o), 0);
                tick(); cyc++;
            end
            bus.tr_ready = 1'b0;
            cur = nxt;
        end
        ep_m = ep_m + 16'd1;
        chk("done_pulse",   32'(episode_done_o), 1);
        chk("done_latency", 32'(cyc), 32'(3 * steps + 1 + stall_sum));
        chk("done_busy",    32'(busy_o), 1);
        chk("done_goal",    32'(done_goal_o), 32'(cur == GOAL));
        chk("done_steps",   32'(step_count_o), 32'(steps));
        chk("done_epcnt",   32'(episode_count_o), 32'(ep_m));
        chk("done_trv",     32'(bus.tr_valid), 0);
        start_i = 1'b0;
        tick();
        chk("post_done", 32'(episode_done_o), 0);
        chk("post_busy", 32'(busy_o), 0);
        chk("post_goal", 32'(done_goal_o), 32'(cur == GOAL));
        chk("post_step", 32'(step_count_o), 32'(steps));
    endtask

    initial begin
        bus.tr_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        lfsr_m = 8'hA5;
        ep_m   = '0;
        chk_reset_state();
        tick();
        chk("idle_stays", 32'(busy_o), 0);

        // reset during WAIT of step 2, then normal runs
        run_episode(5'd4, 1, 0, 0, 2);
        run_episode(5'd4, 1, 0, 0, 0);   // mostly Down toward goal
        run_episode(5'd0, 0, 0, 0, 0);   // mostly Up from top-left: blocked, timeout
        run_episode(5'd5, 3, 0, 0, 0);   // Left from column 0
        run_episode(GOAL, 1, 0, 0, 0);   // start on the goal still takes a step
        run_episode(5'd7, -1, 5, 5, 0);  // five-cycle stall on every record
        for (int i = 0; i < 14; i++)
            run_episode(5'($urandom_range(24, 0)), -1, 0, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
